// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, start-bit validation, 3-sample
// majority vote at mid-cell, 1-clk valid / frame_err strobes.
module uart_rx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD_HZ    = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV_OS = CLK_HZ / (BAUD_HZ * OVERSAMPLE);
  localparam int DIV_W  = (DIV_OS > 1) ? $clog2(DIV_OS) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_d;
  logic             rx_m, rx_s, rx_d;
  logic             fall;
  logic [DIV_W-1:0] os_div;
  logic             os_tick;
  logic [3:0]       os_cnt;
  logic [1:0]       samp;
  logic             maj;
  logic             decide, wrap;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_idx;
  logic             clr, shift_en, idx_inc, idx_clr, load, err;

  // Synchronizer and edge flops idle high so reset release is not a start edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign fall    = rx_d & ~rx_s;
  assign os_tick = (os_div == DIV_W'(DIV_OS - 1));
  assign decide  = os_tick && (os_cnt == 4'd9);
  assign wrap    = os_tick && (os_cnt == 4'd15);
  // samp holds the samples from ticks 7 and 8; tick 9 is rx_s itself.
  assign maj     = (samp[1] & samp[0]) | (samp[1] & rx_s) | (samp[0] & rx_s);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_div <= '0;
      os_cnt <= '0;
      samp   <= '0;
    end else if (clr) begin
      os_div <= '0;
      os_cnt <= '0;
      samp   <= '0;
    end else begin
      os_div <= os_tick ? '0 : os_div + 1'b1;
      if (os_tick) begin
        os_cnt <= os_cnt + 4'd1;
        if (os_cnt == 4'd7 || os_cnt == 4'd8)
          samp <= {samp[0], rx_s};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state;
    clr      = 1'b0;
    shift_en = 1'b0;
    idx_inc  = 1'b0;
    idx_clr  = 1'b0;
    load     = 1'b0;
    err      = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          clr     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (decide && maj) begin
          state_d = IDLE;
        end else if (wrap) begin
          idx_clr = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (decide) shift_en = 1'b1;
        if (wrap) begin
          if (bit_idx == 3'd7) state_d = STOP;
          else                 idx_inc = 1'b1;
        end
      end
      STOP: begin
        if (decide) begin
          load    = maj;
          err     = ~maj;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_idx   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= load;
      frame_err <= err;
      if (shift_en) shift_reg <= {maj, shift_reg[7:1]};
      if (idx_clr)      bit_idx <= '0;
      else if (idx_inc) bit_idx <= bit_idx + 3'd1;
      if (load) data <= shift_reg;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bit-banged 8N1 frames at several baud
// rates, compared against a queue of bytes the line model says are good.
module tb_uart_rx;

  localparam int DIV_OS  = 27;
  localparam int BIT_NOM = 434;
  localparam int LAT_EXP = 154 * DIV_OS + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int vcnt   = 0;
  int fcnt   = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         vt_q[$];
  logic [7:0] last_good = 8'h00;

  uart_rx dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && valid) begin
      vcnt++;
      got_q.push_back(data);
      vt_q.push_back(cyc);
      check("valid_excl_ferr", frame_err, 1'b0);
    end
    if (!rst && frame_err) fcnt++;
  end

  // Line driver: start bit, 8 data bits LSB first, stop bit, each bc clocks.
  task automatic send_frame(input logic [7:0] b, input int bc, input logic stop_val);
    rx = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bc) @(negedge clk);
    end
    rx = stop_val;
    repeat (bc) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_good(input logic [7:0] b);
    exp_q.push_back(b);
    last_good = b;
  endtask

  task automatic drain(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    vt_q.delete();
  endtask

  initial begin
    #(2_500_000);
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int v0, f0, t0, gap, bdur, bc;
    logic [7:0] b;

    #5;
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    idle(50);
    check("post_rst_busy", busy, 1'b0);

    // Single frame, with start-edge to valid latency.
    v0 = vcnt; f0 = fcnt; t0 = cyc;
    send_frame(8'hA5, BIT_NOM, 1'b1);
    expect_good(8'hA5);
    idle(BIT_NOM);
    check("a5_latency_ok", (vt_q.size() == 1) &&
          (vt_q[0] - t0 >= LAT_EXP - DIV_OS) && (vt_q[0] - t0 <= LAT_EXP + DIV_OS), 1'b1);
    check("a5_vcnt", vcnt - v0, 1);
    check("a5_ferr", fcnt - f0, 0);
    check("a5_data", data, 8'hA5);
    check("a5_busy_after", busy, 1'b0);
    drain("a5");

    // Back-to-back frames: second start bit right after first stop bit.
    send_frame(8'h00, BIT_NOM, 1'b1);
    send_frame(8'hFF, BIT_NOM, 1'b1);
    expect_good(8'h00);
    expect_good(8'hFF);
    idle(BIT_NOM);
    gap = (vt_q.size() == 2) ? vt_q[1] - vt_q[0] : 0;
    check("b2b_gap_ok", (gap >= 10*BIT_NOM - DIV_OS) && (gap <= 10*BIT_NOM + DIV_OS), 1'b1);
    check("b2b_data", data, 8'hFF);
    drain("b2b");

    // Short low glitch: false start, busy for ~10 oversample ticks.
    v0 = vcnt; f0 = fcnt; bdur = 0;
    rx = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i == 100) rx = 1'b1;
      @(negedge clk);
      if (busy) bdur++;
    end
    check("glitch_busy_len_ok", (bdur >= 10*DIV_OS - DIV_OS) && (bdur <= 10*DIV_OS + DIV_OS), 1'b1);
    check("glitch_no_valid", vcnt - v0, 0);
    check("glitch_no_ferr", fcnt - f0, 0);
    check("glitch_busy_end", busy, 1'b0);

    // Framing error followed by a 20-bit break; no retrigger while low.
    v0 = vcnt; f0 = fcnt;
    send_frame(8'h55, BIT_NOM, 1'b0);
    repeat (19*BIT_NOM) @(negedge clk);
    check("brk_ferr", fcnt - f0, 1);
    check("brk_no_valid", vcnt - v0, 0);
    check("brk_data_kept", data, last_good);
    check("brk_busy", busy, 1'b0);
    idle(2*BIT_NOM);
    send_frame(8'h3C, BIT_NOM, 1'b1);
    expect_good(8'h3C);
    idle(BIT_NOM);
    check("after_brk_data", data, 8'h3C);
    check("after_brk_ferr", fcnt - f0, 1);
    drain("brk");

    // Asynchronous reset in the middle of data bit 4.
    v0 = vcnt; f0 = fcnt;
    fork
      send_frame(8'h81, BIT_NOM, 1'b1);
      begin
        repeat (5*BIT_NOM + BIT_NOM/2) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_data", data, 8'h00);
        check("mid_rst_valid", valid, 1'b0);
        check("mid_rst_ferr", frame_err, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
      end
    join
    last_good = 8'h00;
    rst = 1'b0;
    idle(BIT_NOM);
    check("abort_no_pulse", (vcnt - v0) + (fcnt - f0), 0);
    send_frame(8'h81, BIT_NOM, 1'b1);
    expect_good(8'h81);
    idle(BIT_NOM);
    check("rst_recover_data", data, 8'h81);
    drain("rst");

    // Transmitter baud offset of +/-2%.
    f0 = fcnt;
    send_frame(8'hC3, 425, 1'b1);
    idle(BIT_NOM);
    expect_good(8'hC3);
    send_frame(8'hC3, 443, 1'b1);
    idle(BIT_NOM);
    expect_good(8'hC3);
    check("baud_ofs_ferr", fcnt - f0, 0);
    drain("baud");

    // Random bytes at random baud within the tolerated range.
    for (int k = 0; k < 3; k++) begin
      b  = 8'($urandom_range(0, 255));
      bc = $urandom_range(425, 443);
      send_frame(b, bc, 1'b1);
      expect_good(b);
      idle($urandom_range(1, BIT_NOM));
    end
    idle(BIT_NOM);
    check("rand_ferr", fcnt - f0, 0);
    check("rand_last_data", data, last_good);
    drain("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
